// File: rtl/emern_pkg.sv
// Shared definitions for the emern tiny GPU: default VGA timing, register map,
// the rectangle record and helpers for writing and hit-testing rectangles.
package emern_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam logic [3:0] ADDR_BG     = 4'h0;
  localparam logic [3:0] ADDR_R0     = 4'h1;
  localparam logic [3:0] ADDR_R0_END = 4'h5;
  localparam logic [3:0] ADDR_R1     = 4'h6;
  localparam logic [3:0] ADDR_R1_END = 4'hA;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    logic [5:0] colour;
    logic       en;
  } rect_t;

  // field is the register offset within a rectangle's five-register block
  function automatic rect_t rect_write(rect_t r, logic [3:0] field, logic [11:0] d);
    rect_t n;
    n = r;
    case (field)
      4'd0:    n.x0 = d[9:0];
      4'd1:    n.x1 = d[9:0];
      4'd2:    n.y0 = d[9:0];
      4'd3:    n.y1 = d[9:0];
      4'd4:    {n.en, n.colour} = d[6:0];
      default: n = r;
    endcase
    return n;
  endfunction

  function automatic logic rect_hit(rect_t r, logic [9:0] h, logic [9:0] v);
    return r.en && (r.x0 <= h) && (h <= r.x1) && (r.y0 <= v) && (v <= r.y1);
  endfunction

endpackage

// File: rtl/emern_spi_rx.sv
// Write-only SPI mode-0 receiver: synchronises the pins into the clk domain and
// assembles 16-bit {addr,data} words, pulsing wr_en once per completed word.
module emern_spi_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs,
  output logic        wr_en,
  output logic [3:0]  addr,
  output logic [11:0] data,
  output logic        cs_fall
);

  logic [2:0]  sck_q;
  logic [1:0]  mosi_q;
  logic [2:0]  cs_q;
  logic [14:0] shift;
  logic [3:0]  bit_cnt;
  logic        sck_rise;
  logic        cs_low;

  // Bit 2 of the sck/cs chains is the previous synchronised value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 3'b111;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
      cs_q   <= {cs_q[1:0], cs};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_low   = ~cs_q[1];
  assign cs_fall  = cs_q[2] & ~cs_q[1];

  // A high cs drops any partial word; the 4-bit counter wraps after each full word
  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      wr_en   <= 1'b0;
      addr    <= '0;
      data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (!cs_low) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift   <= {shift[13:0], mosi_q[1]};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          wr_en        <= 1'b1;
          {addr, data} <= {shift, mosi_q[1]};
        end
      end
    end
  end

endmodule

// File: rtl/emern_top.sv
// emern tiny GPU: VGA timing, background plus two prioritised rectangles,
// SPI-programmed shadow registers latched per frame, and a vblank interrupt.
module emern_top
  import emern_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  h, v;
  logic        frame_end;
  logic        wr_en, cs_fall;
  logic [3:0]  addr;
  logic [11:0] data;
  logic [5:0]  bg_sh, bg_act, colour;
  rect_t       r0_sh, r1_sh, r0_act, r1_act;
  logic        hsync, vsync, int_q;
  logic        unused_ok;

  assign unused_ok = &{1'b0, ena, ui_in, uio_in[7:4], uio_in[2]};
  assign frame_end = (h == H_LAST) && (v == V_LAST);

  emern_spi_rx u_spi (
    .clk     (clk),
    .rst     (rst_n),
    .sck     (uio_in[3]),
    .mosi    (uio_in[1]),
    .cs      (uio_in[0]),
    .wr_en   (wr_en),
    .addr    (addr),
    .data    (data),
    .cs_fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Shadow takes SPI writes any time; active copies shadow only at the last pixel of a frame
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bg_sh  <= '0;
      r0_sh  <= '0;
      r1_sh  <= '0;
      bg_act <= '0;
      r0_act <= '0;
      r1_act <= '0;
    end else begin
      if (wr_en) begin
        if (addr == ADDR_BG)
          bg_sh <= data[5:0];
        else if (addr >= ADDR_R0 && addr <= ADDR_R0_END)
          r0_sh <= rect_write(r0_sh, addr - ADDR_R0, data);
        else if (addr >= ADDR_R1 && addr <= ADDR_R1_END)
          r1_sh <= rect_write(r1_sh, addr - ADDR_R1, data);
      end
      if (frame_end) begin
        bg_act <= bg_sh;
        r0_act <= r0_sh;
        r1_act <= r1_sh;
      end
    end
  end

  always_comb begin
    colour = bg_act;
    if (rect_hit(r1_act, h, v))
      colour = r1_act.colour;
    else if (rect_hit(r0_act, h, v))
      colour = r0_act.colour;
    if (!(h < H_VIS && v < V_VIS))
      colour = 6'd0;
  end

  assign hsync = !(h >= H_SS && h <= H_SE);
  assign vsync = !(v >= V_SS && v <= V_SE);

  // TinyVGA pin order interleaves the MSBs on [2:0] and LSBs on [6:4]
  always_ff @(posedge clk) begin
    if (rst_n)
      uo_out <= 8'h88;
    else
      uo_out <= {hsync, colour[0], colour[2], colour[4], vsync, colour[1], colour[3], colour[5]};
  end

  // Set has priority over both clear sources
  always_ff @(posedge clk) begin
    if (rst_n)
      int_q <= 1'b0;
    else if (h == 10'd0 && v == V_VIS)
      int_q <= 1'b1;
    else if (cs_fall || frame_end)
      int_q <= 1'b0;
  end

  assign uio_out = {3'b000, int_q, 4'b0000};
  assign uio_oe  = 8'h10;

endmodule

// File: tb/tb_emern_top.sv
// Scoreboard bench for emern_top on a shrunken VGA raster: a frame-level model
// queues the expected pins each clk and a monitor compares them on the falling edge.
module tb_emern_top;

  localparam int HA = 40, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    bit         dc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       sck = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic [7:0] uio_in, uo_out, uio_out, uio_oe;

  logic [11:0] sh [16];
  logic [11:0] act[16];
  int          mh = 0, mv = 0, int_dc = 0;
  logic        int_exp = 1'b0;
  exp_t        exp_q[$];
  int          n_checks = 0, n_pass = 0;

  assign uio_in = {4'b0000, sck, 1'b0, mosi, cs};

  emern_top #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, logic [7:0] got, logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s at %0t (v=%0d h=%0d): got %h, expected %h", name, $time, mv, mh, got, want);
  endtask

  // Rectangle whose registers start at address base covers pixel (h,v)
  function automatic bit covers(int base, int h, int v);
    int x0, x1, y0, y1;
    x0 = int'(act[base][9:0]);
    x1 = int'(act[base + 1][9:0]);
    y0 = int'(act[base + 2][9:0]);
    y1 = int'(act[base + 3][9:0]);
    return act[base + 4][6] && h >= x0 && h <= x1 && v >= y0 && v <= y1;
  endfunction

  function automatic logic [7:0] pixel_exp(int h, int v);
    logic [5:0] c;
    logic [1:0] r, g, b;
    logic       hs, vs;
    hs = !(h >= HA + HFP && h < HA + HFP + HS);
    vs = !(v >= VA + VFP && v < VA + VFP + VS);
    c = 6'd0;
    if (h < HA && v < VA) begin
      if (covers(6, h, v))      c = act[10][5:0];
      else if (covers(1, h, v)) c = act[5][5:0];
      else                      c = act[0][5:0];
    end
    r = c[5:4]; g = c[3:2]; b = c[1:0];
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // Reference model: one raster step per clk, registered outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      e.dc = (int_dc > 0);
      if (int_dc > 0) int_dc--;
      if (rst_n) begin
        mh = 0; mv = 0; int_exp = 1'b0;
        for (int i = 0; i < 16; i++) begin sh[i] = '0; act[i] = '0; end
        e.uo = 8'h88;
      end else begin
        e.uo = pixel_exp(mh, mv);
        if (mh == 0 && mv == VA) int_exp = 1'b1;
        else if (mh == HT - 1 && mv == VT - 1) int_exp = 1'b0;
        if (mh == HT - 1 && mv == VT - 1)
          for (int i = 0; i < 16; i++) act[i] = sh[i];
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else mh++;
      end
      e.uio = {3'b000, int_exp, 4'b0000};
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("uo_out", uo_out, e.uo);
        check_output("uio_oe", uio_oe, 8'h10);
        if (!e.dc) check_output("uio_out", uio_out, e.uio);
      end
    end
  end

  task automatic wait_pos(int v, int h);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(mv == v && mh == h) && n < 2 * HT * VT);
    if (!(mv == v && mh == h)) begin
      n_checks++;
      $display("[TB] FAIL wait_pos timeout: at v=%0d h=%0d, required v=%0d h=%0d", mv, mh, v, h);
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    int_exp = 1'b0;
    int_dc = 2;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_word(logic [15:0] w, int nbits, int half);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15 - i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
    if (nbits == 16) sh[w[15:12]] = w[11:0];
  endtask

  task automatic apply_stimulus();
    logic [3:0]  a;
    logic [11:0] d;
    int          half, nw;

    repeat (6) @(negedge clk);
    rst_n = 1'b0;

    // BG red, cs held low across the frame boundary; int is high here and the fall clears it
    wait_pos(VA + 1, 0);
    cs_low();
    spi_word(16'h0030, 16, 2);
    wait_pos(1, 0);
    cs_high();

    wait_pos(0, 2);
    cs_low();
    spi_word(16'h100A, 16, 2); spi_word(16'h2013, 16, 2);
    spi_word(16'h3005, 16, 2); spi_word(16'h4006, 16, 2);
    spi_word(16'h504C, 16, 2);
    spi_word(16'h600F, 16, 2); spi_word(16'h701E, 16, 2);
    spi_word(16'h8005, 16, 2); spi_word(16'h9005, 16, 2);
    spi_word(16'hA043, 16, 2);
    cs_high();
    wait_pos(0, 2);

    // Partial word discarded by cs high, then a full BG write
    wait_pos(0, 2);
    cs_low();
    spi_word(16'h0FFF, 10, 2);
    cs_high();
    cs_low();
    spi_word(16'h0015, 16, 2);
    cs_high();
    wait_pos(0, 2);

    for (int it = 0; it < 5; it++) begin
      wait_pos(0, 2);
      half = $urandom_range(2, 3);
      nw = $urandom_range(6, 11);
      cs_low();
      for (int k = 0; k < nw; k++) begin
        a = 4'($urandom_range(0, 15));
        case (a)
          4'd1, 4'd2, 4'd6, 4'd7: d = 12'($urandom_range(0, HA + 3)) | (12'($urandom_range(0, 3)) << 10);
          4'd3, 4'd4, 4'd8, 4'd9: d = 12'($urandom_range(0, VA + 3)) | (12'($urandom_range(0, 3)) << 10);
          4'd5, 4'd10: begin
            d = 12'($urandom);
            d[6] = ($urandom_range(0, 3) != 0);
          end
          default: d = 12'($urandom);
        endcase
        spi_word({a, d}, 16, half);
      end
      cs_high();
    end
    wait_pos(0, 2);

    // Reset in the middle of a word, then a clean write
    wait_pos(0, 2);
    cs_low();
    spi_word(16'h0FFF, 8, 2);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    wait_pos(0, 2);
    cs_low();
    spi_word(16'h002A, 16, 3);
    cs_high();
    wait_pos(0, 2);
    wait_pos(VA + 2, 0);
  endtask

  initial begin
    $display("[TB] emern_top scoreboard run, raster %0dx%0d", HT, VT);
    apply_stimulus();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/emern_top.md
Name: emern_top

Overview:
- Tiny fixed-function GPU for a TinyTapeout tile.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock and drives 2-bit-per-channel RGB on the TinyVGA pinout.
- Each pixel is composed from a background colour plus two prioritised filled rectangles; all are programmed over a write-only SPI slave.
- An interrupt output tells the host when vertical blanking starts.

Parameters:
- H_ACTIVE, 640, visible pixels per line (H_FP 16, H_SYNC 96, H_BP 48; total 800)
- V_ACTIVE, 480, visible lines (V_FP 10, V_SYNC 2, V_BP 33; total 525)

Ports:
- clk  in  1  pixel clock, 25 MHz; the only clock.
- rst_n  in  1  synchronous reset, active-high; asserted when 1, sampled on rising clk.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  unused.
- uo_out  out  8  [0]=R1 [4]=R0, [1]=G1 [5]=G0, [2]=B1 [6]=B0, [7]=hsync, [3]=vsync.
- uio_in  in  8  [3]=spi_sck, [1]=spi_mosi, [0]=spi_cs (active-low); others ignored.
- uio_out  out  8  [4]=int_out; all other bits 0.
- uio_oe  out  8  constant 8'h10.

Behaviour:
- Counters: h 0..799 increments every clk; at 799 it wraps to 0 and v advances 0..524, wrapping to 0.
- hsync is low for h in 656..751; vsync is low for v in 490..491. Both are active-low.
- Outputs are registered, so the colour and sync for (h,v) appear on uo_out one clk later.
- Outside h<640 and v<480, RGB = 0.
- Pixel colour, highest priority first:
  - R1 if enabled and x0<=h<=x1 and y0<=v<=y1 (inclusive bounds);
  - else R0 under the same rule;
  - else BG.
  - A rectangle with x0>x1 or y0>y1 never hits.
- Colour format is 6 bits RRGGBB.
- SPI input handling:
  - sck, mosi and cs each pass through a 2-FF synchroniser.
  - Mode 0: mosi is sampled on the synchronised sck rising edge, MSB first.
  - Required sck <= clk/4.
- SPI framing:
  - While cs is low, bits shift into a 16-bit word: [15:12]=addr, [11:0]=data.
  - Each 16th bit completes a write to a shadow register. Several words may be sent in one cs-low period.
  - cs rising with a partial word discards it; the bit counter resets on cs high.
- Shadow register map (unused high bits ignored):
  - 0x0 BG[5:0]
  - 0x1 R0.x0[9:0], 0x2 R0.x1, 0x3 R0.y0, 0x4 R0.y1
  - 0x5 R0.colour[5:0] and R0.en at bit 6
  - 0x6..0xA: R1, same layout
  - 0xB..0xF are ignored.
- Active registers copy from shadow on the single clk where h=799 and v=524.
  - Writes become visible from the next frame start.
  - A write completing in that same clk lands in shadow and is picked up next frame.
- int_out:
  - Set (registered) in the clk following h=0, v=480.
  - Cleared by a detected cs falling edge or by v wrapping to 0.
  - If set and clear happen on the same clk, set wins.
- Reset (rst_n=1): h=v=0; all shadow and active registers 0 (BG black, rectangles disabled); shift state cleared; uo_out = 8'h88 (syncs high, RGB 0); int_out=0.
- Reset mid-operation aborts any SPI word in progress.

Decomposition:
- Package emern_pkg:
  - VGA timing constants: totals, sync start and end.
  - Register address localparams.
  - Rectangle struct {x0,x1,y0,y1,colour,en}.
- One natural sub-module: emern_spi_rx. It contains the synchroniser, shifter and bit counter and emits wr_en, addr[3:0], data[11:0] plus a cs_fall pulse.
- Timing, compositing and interrupt logic stay in top.

Test Plan:
- Reset, then release:
  - uo_out=8'h88 and uio_oe=8'h10 during reset.
  - First hsync low exactly 657 clk after release, lasting 96 clk; period 800 clk.
- Count a frame:
  - vsync low for 2 lines (1600 clk) starting at line 490; frame period 420000 clk.
- SPI write addr 0x0 data 0x030, with cs held across the frame end:
  - From next frame, visible pixels are R=3, G=0, B=0 (uo_out[0]=uo_out[4]=1).
  - Blanking pixels have RGB 0.
- Program R0 = x 10..19, y 5..6, colour 0x0C, en=1, and R1 = x 15..30, y 5..5, colour 0x03, en=1:
  - At line 5, pixels 10..14 are green=3, 15..30 blue=3, others BG.
  - At line 6, pixels 10..19 are green.
- int_out:
  - Rises 1 clk after (h=0, v=480).
  - A cs falling edge clears it within 3 clk.
  - Without SPI activity it stays high until v wraps to 0.
- Send 10 bits then raise cs, then a full word 0x0015:
  - The partial word has no effect.
  - BG becomes 0x15 next frame.
